mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
HI/LO multiply/divide unit in the EX stage of the P6 pipeline. It consumes the decoder's start, multdivOP, HIWrite, LOWrite and HILOOP controls, performs multi-cycle mult/multu/div/divu, and holds the HI and LO registers. It drives busy to the hazard unit and drives the mfhi/mflo read data to the EX result mux.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
A  in  32  rs operand (forwarded)
B  in  32  rt operand (forwarded)
start  in  2  01 = mult-class, 10 = div-class, 00 = none; 11 is illegal and treated as 00
multdivOP  in  2  00 mult, 01 multu, 10 div, 11 divu
HIWrite  in  1  mthi: HI <= A
LOWrite  in  1  mtlo: LO <= A
HILOOP  in  1  read select: 1 = HI, 0 = LO
busy  out  1  operation in progress
out  out  32  HILOOP ? HI : LO (combinational)

Behaviour:
- Reset (async assert, sync release): state IDLE, counter 0, HI = LO = 0, pending result = 0, busy = 0, out = 0.
- States:
  - IDLE: busy = 0.
  - RUN: busy = 1, counter counts down.
- IDLE with start = 01 or 10 at a clock edge:
  - capture A, B and multdivOP;
  - compute the 64-bit result into the pending register;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- busy is high for exactly N cycles, starting the cycle after the start edge.
- On the edge where counter = 1: HI/LO <= pending, state <= IDLE. The new HI/LO value is visible on out in the first cycle busy = 0.
- HI/LO keep their old values throughout RUN, so out shows the old values while busy.
- mult: signed 32x32 -> 64; multu: unsigned. HI = [63:32], LO = [31:0].
- div: signed quotient truncates toward zero; remainder takes the sign of the dividend. LO = quotient, HI = remainder.
- divu: unsigned; LO = quotient, HI = remainder.
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (B = 0): runs the full DIV_CYCLES; HI/LO are unchanged at completion.
- start while busy = 1: ignored (the hazard unit stalls on start && busy).
- HIWrite/LOWrite while busy = 1: ignored.
- HIWrite/LOWrite in IDLE: register written at the edge.
- HIWrite and LOWrite together: both registers get A.
- start together with HIWrite/LOWrite in IDLE: start wins, the write is dropped (the decoder never issues this).
- Counter width: clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1 bits. No wrap: the counter is only loaded from IDLE.
- Reset mid-RUN: operation aborted, HI/LO = 0, busy falls immediately (async).
- Throughput: back-to-back starts are possible. A start on the first IDLE cycle after completion is accepted.

Decomposition:
- Package mdu_pkg:
  - START_NONE / START_MULT / START_DIV (2-bit)
  - OP_MULT / OP_MULTU / OP_DIV / OP_DIVU
  - state encodings IDLE / RUN
  - default cycle constants
- Sub-module multdiv_core: combinational, inputs A, B, op; outputs res[63:0] and div_zero. It keeps the arithmetic and sign handling out of the FSM. The top level holds the FSM, counter, pending register and HI/LO.

Test Plan:
- mult A=0xFFFFFFFE, B=3:
  - busy high 5 cycles;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Same operands with multu: HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9, B=2:
  - busy 10 cycles;
  - then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2: LO=3, HI=1.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Setup mthi 0x1234, mtlo 0x5678. Then divu A=9, B=0: busy 10 cycles; HI=0x1234, LO=0x5678 unchanged; out tracks HILOOP.
- During a mult (busy):
  - start=10 and HIWrite with A=0xDEAD are issued; both are ignored, and the mult result commits at cycle 5.
  - out shows pre-mult HI/LO until busy falls.
- Pull reset low at RUN cycle 3 of a div: busy, HI, LO = 0 immediately; after release, a new mult completes normally.
- Back-to-back: mult issued on the first IDLE cycle after a div completes is accepted. Busy shows 10 high, 1 low, 5 high, and both results are correct.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Start classes, operation codes, FSM states and default latencies.
package mdu_pkg;

  localparam logic [1:0] START_NONE = 2'b00;
  localparam logic [1:0] START_MULT = 2'b01;
  localparam logic [1:0] START_DIV  = 2'b10;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/multdiv_core.sv
// Combinational 32x32 multiply and divide with MIPS sign rules.
// res = {HI, LO}; div_zero flags a divide with a zero divisor.
import mdu_pkg::*;

module multdiv_core (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  op,
  output logic [63:0] res,
  output logic        div_zero
);

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        neg_a;
  logic        neg_b;
  logic        is_signed;

  always_comb begin
    is_signed = ~op[0];
    div_zero  = op[1] && (B == 32'd0);
    // Low 64 bits of a product of sign/zero-extended operands are exact.
    ext_a = is_signed ? {{32{A[31]}}, A} : {32'd0, A};
    ext_b = is_signed ? {{32{B[31]}}, B} : {32'd0, B};
    // Divide on magnitudes, then restore signs: truncation toward zero.
    neg_a  = is_signed && A[31];
    neg_b  = is_signed && B[31];
    mag_a  = neg_a ? -A : A;
    mag_b  = neg_b ? -B : B;
    safe_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo    = mag_a / safe_b;
    rem    = mag_a % safe_b;
    if (neg_a ^ neg_b) quo = -quo;
    if (neg_a) rem = -rem;
    res = '0;
    unique case (op)
      OP_MULT, OP_MULTU: res = ext_a * ext_b;
      OP_DIV, OP_DIVU:   res = {rem, quo};
      default:           res = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage HI/LO multiply/divide unit: multi-cycle FSM with busy flag.
// Result is computed at issue and committed to HI/LO on the final cycle.
import mdu_pkg::*;

module mult_div_unit #(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  start,
  input  logic [1:0]  multdivOP,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        HILOOP,
  output logic        busy,
  output logic [31:0] out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   pend;
  logic          pend_skip;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [63:0]   res;
  logic          div_zero;
  logic          go;

  multdiv_core u_core (
    .A        (A),
    .B        (B),
    .op       (multdivOP),
    .res      (res),
    .div_zero (div_zero)
  );

  assign go  = (start == START_MULT) || (start == START_DIV);
  assign out = HILOOP ? hi : lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= '0;
      pend_skip <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            pend      <= res;
            pend_skip <= div_zero;
            cnt       <= (start == START_MULT) ? CW'(MULT_CYCLES)
                                               : CW'(DIV_CYCLES);
            state     <= RUN;
            busy      <= 1'b1;
          end else begin
            if (HIWrite) hi <= A;
            if (LOWrite) lo <= A;
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            if (!pend_skip) begin
              hi <= pend[63:32];
              lo <= pend[31:0];
            end
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
